mips_wb_unit: RTL and testbench
===============================

Name: mips_wb_unit

Overview:
Write-back unit: the producer side of the register-file write port (Wdata, write address, write enable), consumed by the ID-stage register file. It classifies the retiring instruction and selects Wdata from the ALU result, the data-memory read data, or nextPC for JAL/JALR. It runs LW/SW through a req/ack data-memory handshake with timeout, and stalls the front end while a memory access is outstanding.

Parameters:
TIMEOUT, 16, max cycles waiting for DMEM_ACK before abort (must be >= 2)
CNT_W, 5, width of the timeout counter (must satisfy 2**CNT_W > TIMEOUT)

Ports:
CLK  in  1  clock
RST  in  1  synchronous reset, active-high
IN_VALID  in  1  Ins/Result/nextPC/Rdata2 valid this cycle
Ins  in  32  retiring instruction
Result  in  32  ALU result; effective address for LW/SW
nextPC  in  32  PC+4 of the retiring instruction
Rdata2  in  32  store data for SW
DMEM_REQ  out  1  memory request, held until ack
DMEM_WE  out  1  1 = store, 0 = load; valid with DMEM_REQ
DMEM_ADDR  out  32  word address (Result)
DMEM_WDATA  out  32  store data
DMEM_RDATA  in  32  load data, valid with DMEM_ACK
DMEM_ACK  in  1  one-cycle completion pulse
WE  out  1  register-file write enable
WADR  out  5  register-file write address
Wdata  out  32  register-file write data
STALL  out  1  upstream must hold and must not assert IN_VALID
ERR  out  1  sticky memory-timeout flag

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous and active-high on RST. RST has priority over everything else, including mid-handshake: state goes to IDLE, and DMEM_REQ, DMEM_WE, WE, STALL and ERR go to 0. WADR, Wdata, DMEM_ADDR and DMEM_WDATA reset to 0. The counter clears.
- Classification (op = Ins[31:26], funct = Ins[5:0]):
  - Writers using Result: R_FORM with ADD/ADDU/SUB/SUBU/AND/OR/XOR/NOR/SLT/SLTU/SLL/SRL/SRA/SLLV/SRLV/SRAV, and ADDI/ADDIU/SLTI/SLTIU/ANDI/ORI/XORI.
  - Writers using nextPC: JAL (WADR = 31) and JALR (WADR = rd).
  - LW: memory read, WADR = rt.
  - SW: memory write, no register write.
  - Everything else (JR, J, branches, unknown codes) retires with no write.
  - WADR is rd for R_FORM, rt for I-type, 31 for JAL.
- FSM states: IDLE, MEM, WB.
  - IDLE, IN_VALID with a non-memory writer: the next cycle drives WE = 1 for exactly one cycle, with WADR and Wdata registered. Latency is 1. The FSM stays in IDLE and STALL stays 0, so back-to-back instructions are accepted every cycle.
  - IDLE, IN_VALID with LW or SW: next cycle DMEM_REQ = 1, DMEM_WE = (SW), ADDR and WDATA are latched, STALL = 1, and the FSM goes to MEM. STALL rises combinationally in the accept cycle so no second instruction is taken.
  - MEM: DMEM_REQ and all address/data fields are held stable until DMEM_ACK. The counter increments each cycle.
    - On DMEM_ACK with a load: latch DMEM_RDATA and go to WB.
    - On DMEM_ACK with a store: drop REQ and STALL next cycle and go to IDLE.
    - If the counter reaches TIMEOUT with no ACK: drop REQ, set ERR = 1 (sticky until RST), suppress any write, and go to IDLE.
    - ACK in the same cycle the counter hits TIMEOUT counts as success.
  - WB: WE = 1 for one cycle with Wdata = latched load data, STALL = 1, then go to IDLE. STALL falls in the cycle after WE.
  - Load-to-use hazard: the earliest a dependent instruction can be accepted is the cycle after WE, so the register file already holds the loaded value.
- Register 0: any write with WADR = 0 is suppressed (WE stays 0). The memory access for LW rt = 0 still occurs.
- DMEM_ACK outside MEM is ignored. IN_VALID while STALL = 1 is a protocol violation and is ignored; the bench asserts that it never occurs.
- Widths: all data paths are 32-bit pass-through. No sign or byte handling in this block.

Decomposition:
- Op and funct constants (R_FORM, LW, SW, JAL, ADDI…, JR, JALR…) are reused from common_param.vh. Add the FSM state encodings (IDLE = 2'd0, MEM = 2'd1, WB = 2'd2) there as well.
- One combinational sub-module, mips_wb_decode: from Ins it produces the class (NONE/RES/PC/LOAD/STORE) and WADR. This keeps the FSM free of decode logic.

Test Plan:
- ADD, rd = 9, Result = 0x00000011 → the next cycle has WE = 1, WADR = 9, Wdata = 0x11; STALL stays 0.
- JAL, nextPC = 0x0000000C → WE = 1, WADR = 31, Wdata = 0x0C. JR → WE stays 0.
- LW, rt = 8, Result = 0x40, ACK after 3 cycles with RDATA = 0xDEADBEEF:
  - DMEM_REQ = 1 with ADDR = 0x40 and WE = 0 for the whole wait.
  - WE pulses with Wdata = 0xDEADBEEF.
  - STALL covers the accept cycle through the WE cycle.
- SW, Result = 0x44, Rdata2 = 0x5 → DMEM_REQ with DMEM_WE = 1 and WDATA = 0x5; after ACK there is no WE pulse and STALL clears.
- LW with no ACK, TIMEOUT = 16 → REQ drops after 16 cycles, ERR = 1, no WE. RST then clears ERR.
- RST asserted in MEM → the next cycle has REQ = 0, STALL = 0, state IDLE. A late ACK is ignored. ADDI with rt = 0 never raises WE.

Source files
------------

// File: rtl/mips_wb_unit_pkg.sv
// mips_wb_unit_pkg: MIPS opcode/funct constants, write-back instruction classes and FSM state encodings
package mips_wb_unit_pkg;
    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] F_SLL    = 6'h00;
    localparam logic [5:0] F_SRL    = 6'h02;
    localparam logic [5:0] F_SRA    = 6'h03;
    localparam logic [5:0] F_SLLV   = 6'h04;
    localparam logic [5:0] F_SRLV   = 6'h06;
    localparam logic [5:0] F_SRAV   = 6'h07;
    localparam logic [5:0] F_JR     = 6'h08;
    localparam logic [5:0] F_JALR   = 6'h09;
    localparam logic [5:0] F_ADD    = 6'h20;
    localparam logic [5:0] F_ADDU   = 6'h21;
    localparam logic [5:0] F_SUB    = 6'h22;
    localparam logic [5:0] F_SUBU   = 6'h23;
    localparam logic [5:0] F_AND    = 6'h24;
    localparam logic [5:0] F_OR     = 6'h25;
    localparam logic [5:0] F_XOR    = 6'h26;
    localparam logic [5:0] F_NOR    = 6'h27;
    localparam logic [5:0] F_SLT    = 6'h2a;
    localparam logic [5:0] F_SLTU   = 6'h2b;
    typedef enum logic [2:0] {CL_NONE, CL_RES, CL_PC, CL_LOAD, CL_STORE} wb_class_t;
    typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, WB = 2'd2} wb_state_t;
endpackage

// File: rtl/mips_wb_decode.sv
// mips_wb_decode: classifies the retiring instruction and picks its destination register
//   ins  in  32  retiring instruction
//   cls  out     write-back class (NONE/RES/PC/LOAD/STORE)
//   wadr out 5   destination: rd for R-form, rt for I-type, 31 for JAL
module mips_wb_decode
    import mips_wb_unit_pkg::*;
(
    input  logic [31:0] ins,
    output wb_class_t   cls,
    output logic [4:0]  wadr
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_bits;
    assign op = ins[31:26];
    assign funct = ins[5:0];
    assign unused_bits = ^{ins[25:21], ins[10:6]};
    always_comb begin
        cls = CL_NONE;
        wadr = ins[20:16];
        if (op == OP_RFORM) begin
            wadr = ins[15:11];
            case (funct)
                F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR,
                F_SLT, F_SLTU, F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV: cls = CL_RES;
                F_JALR:  cls = CL_PC;
                default: cls = CL_NONE;
            endcase
        end else begin
            case (op)
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: cls = CL_RES;
                OP_JAL: begin
                    cls = CL_PC;
                    wadr = 5'd31;
                end
                OP_LW:   cls = CL_LOAD;
                OP_SW:   cls = CL_STORE;
                default: cls = CL_NONE;
            endcase
        end
    end
endmodule

// File: rtl/mips_wb_unit.sv
// mips_wb_unit: write-back stage driving the register-file write port, with LW/SW memory handshake and timeout
//   CLK, RST                      clock, synchronous active-high reset
//   IN_VALID, Ins, Result,
//   nextPC, Rdata2                retiring instruction and its operands
//   DMEM_REQ/WE/ADDR/WDATA out    data-memory request, held until DMEM_ACK
//   DMEM_RDATA, DMEM_ACK   in     data-memory response
//   WE, WADR, Wdata        out    register-file write port
//   STALL                  out    front-end hold while a memory access is in flight
//   ERR                    out    sticky memory-timeout flag
module mips_wb_unit
    import mips_wb_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        IN_VALID,
    input  logic [31:0] Ins,
    input  logic [31:0] Result,
    input  logic [31:0] nextPC,
    input  logic [31:0] Rdata2,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [31:0] DMEM_WDATA,
    input  logic [31:0] DMEM_RDATA,
    input  logic        DMEM_ACK,
    output logic        WE,
    output logic [4:0]  WADR,
    output logic [31:0] Wdata,
    output logic        STALL,
    output logic        ERR
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    wb_state_t        state, state_n;
    wb_class_t        cls;
    logic [4:0]       dec_wadr, wadr_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             req_n, dwe_n, we_n, err_n, mem_op;
    logic [31:0]      addr_n, wdat_n, wdata_n;
    mips_wb_decode u_dec (.ins(Ins), .cls(cls), .wadr(dec_wadr));
    assign mem_op = (cls == CL_LOAD) || (cls == CL_STORE);
    // Raised combinationally in the accept cycle so the next instruction is held off immediately
    assign STALL = (state != IDLE) || (IN_VALID && mem_op);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            cnt <= '0;
            DMEM_REQ <= 1'b0;
            DMEM_WE <= 1'b0;
            DMEM_ADDR <= '0;
            DMEM_WDATA <= '0;
            WE <= 1'b0;
            WADR <= '0;
            Wdata <= '0;
            ERR <= 1'b0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            DMEM_REQ <= req_n;
            DMEM_WE <= dwe_n;
            DMEM_ADDR <= addr_n;
            DMEM_WDATA <= wdat_n;
            WE <= we_n;
            WADR <= wadr_n;
            Wdata <= wdata_n;
            ERR <= err_n;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        req_n = DMEM_REQ;
        dwe_n = DMEM_WE;
        addr_n = DMEM_ADDR;
        wdat_n = DMEM_WDATA;
        we_n = 1'b0;
        wadr_n = WADR;
        wdata_n = Wdata;
        err_n = ERR;
        case (state)
            IDLE: if (IN_VALID) begin
                wadr_n = dec_wadr;
                if (mem_op) begin
                    state_n = MEM;
                    cnt_n = '0;
                    req_n = 1'b1;
                    dwe_n = cls == CL_STORE;
                    addr_n = Result;
                    wdat_n = Rdata2;
                end else if (cls == CL_RES || cls == CL_PC) begin
                    we_n = dec_wadr != 5'd0;
                    wdata_n = cls == CL_PC ? nextPC : Result;
                end
            end
            // ACK is checked before the timeout so an ACK on the last allowed cycle succeeds
            MEM: if (DMEM_ACK) begin
                req_n = 1'b0;
                state_n = DMEM_WE ? IDLE : WB;
                we_n = !DMEM_WE && WADR != 5'd0;
                wdata_n = DMEM_WE ? Wdata : DMEM_RDATA;
            end else if (cnt == CNT_LAST) begin
                req_n = 1'b0;
                err_n = 1'b1;
                state_n = IDLE;
            end else begin
                cnt_n = cnt + 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mips_wb_unit.sv
// tb_mips_wb_unit: directed vector table plus handshake sequences for mips_wb_unit
module tb_mips_wb_unit;
    logic        CLK = 1'b0;
    logic        RST, IN_VALID, DMEM_ACK;
    logic [31:0] Ins, Result, nextPC, Rdata2, DMEM_RDATA;
    logic        DMEM_REQ, DMEM_WE, WE, STALL, ERR;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, Wdata;
    logic [4:0]  WADR;
    int n_cmp = 0;
    int n_err = 0;

    mips_wb_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .Ins(Ins), .Result(Result),
        .nextPC(nextPC), .Rdata2(Rdata2), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE),
        .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA), .DMEM_RDATA(DMEM_RDATA),
        .DMEM_ACK(DMEM_ACK), .WE(WE), .WADR(WADR), .Wdata(Wdata), .STALL(STALL), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (!RST && IN_VALID && DMEM_REQ) begin
            n_err++;
            $display("FAIL protocol: IN_VALID=1 while memory access outstanding, required 0");
        end
    end

    typedef struct {
        logic [31:0] ins;
        logic [31:0] res;
        logic [31:0] npc;
        logic        we;
        logic [4:0]  wadr;
        logic [31:0] wdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] rf(input logic [5:0] f, input logic [4:0] rd);
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, f};
    endfunction

    function automatic logic [31:0] it(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
        return {op, 5'd3, rt, imm};
    endfunction

    task automatic issue(input logic [31:0] ins, input logic [31:0] res, input logic [31:0] rd2);
        IN_VALID = 1'b1;
        Ins = ins;
        Result = res;
        Rdata2 = rd2;
        #1;
        chk("stall_in_accept_cycle", {31'd0, STALL}, 32'd1);
        tick;
        IN_VALID = 1'b0;
    endtask

    vec_t v[12];
    int   reqc;
    logic saw_we;

    initial begin
        v[0]  = '{rf(6'h20, 5'd9),          32'h11,       32'h4,   1'b1, 5'd9,  32'h11};
        v[1]  = '{{6'h03, 26'h10},          32'h99,       32'hC,   1'b1, 5'd31, 32'hC};
        v[2]  = '{rf(6'h08, 5'd0),          32'h55,       32'h8,   1'b0, 5'd0,  32'h0};
        v[3]  = '{it(6'h08, 5'd0, 16'h7),   32'h7,        32'h10,  1'b0, 5'd0,  32'h0};
        v[4]  = '{it(6'h08, 5'd5, 16'h1234),32'h1234,     32'h14,  1'b1, 5'd5,  32'h1234};
        v[5]  = '{rf(6'h09, 5'd7),          32'h77,       32'h100, 1'b1, 5'd7,  32'h100};
        v[6]  = '{rf(6'h00, 5'd3),          32'hF0,       32'h18,  1'b1, 5'd3,  32'hF0};
        v[7]  = '{rf(6'h3f, 5'd4),          32'h1,        32'h1C,  1'b0, 5'd0,  32'h0};
        v[8]  = '{it(6'h04, 5'd6, 16'h2),   32'h2,        32'h20,  1'b0, 5'd0,  32'h0};
        v[9]  = '{{6'h02, 26'h4},           32'h3,        32'h24,  1'b0, 5'd0,  32'h0};
        v[10] = '{it(6'h0d, 5'd12, 16'hFF), 32'hABCD00FF, 32'h28,  1'b1, 5'd12, 32'hABCD00FF};
        v[11] = '{rf(6'h27, 5'd1),          32'hFFFF0000, 32'h2C,  1'b1, 5'd1,  32'hFFFF0000};
        RST = 1'b1; IN_VALID = 1'b0; DMEM_ACK = 1'b0;
        Ins = 32'h0; Result = 32'h0; nextPC = 32'h0; Rdata2 = 32'h0; DMEM_RDATA = 32'h0;
        tick; tick;
        RST = 1'b0;
        #1;
        chk("reset_req", {31'd0, DMEM_REQ}, 32'd0);
        chk("reset_we", {31'd0, WE}, 32'd0);
        chk("reset_stall", {31'd0, STALL}, 32'd0);
        chk("reset_err", {31'd0, ERR}, 32'd0);
        chk("reset_wadr", {27'd0, WADR}, 32'd0);
        chk("reset_wdata", Wdata, 32'd0);
        chk("reset_addr", DMEM_ADDR, 32'd0);
        chk("reset_dwdata", DMEM_WDATA, 32'd0);
        // back-to-back non-memory instructions, one per cycle
        for (int i = 0; i < 12; i++) begin
            IN_VALID = 1'b1;
            Ins = v[i].ins;
            Result = v[i].res;
            nextPC = v[i].npc;
            #1;
            chk($sformatf("vec%0d_stall", i), {31'd0, STALL}, 32'd0);
            tick;
            chk($sformatf("vec%0d_we", i), {31'd0, WE}, {31'd0, v[i].we});
            if (v[i].we) begin
                chk($sformatf("vec%0d_wadr", i), {27'd0, WADR}, {27'd0, v[i].wadr});
                chk($sformatf("vec%0d_wdata", i), Wdata, v[i].wdata);
            end
        end
        IN_VALID = 1'b0;
        tick;
        chk("idle_we_drop", {31'd0, WE}, 32'd0);
        // LW rt=8 @0x40, ACK on the third waiting cycle
        issue(it(6'h23, 5'd8, 16'h40), 32'h40, 32'h0);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("lw_req_c%0d", k), {31'd0, DMEM_REQ}, 32'd1);
            chk($sformatf("lw_addr_c%0d", k), DMEM_ADDR, 32'h40);
            chk($sformatf("lw_dwe_c%0d", k), {31'd0, DMEM_WE}, 32'd0);
            chk($sformatf("lw_stall_c%0d", k), {31'd0, STALL}, 32'd1);
            chk($sformatf("lw_we_c%0d", k), {31'd0, WE}, 32'd0);
            if (k == 2) begin
                DMEM_ACK = 1'b1;
                DMEM_RDATA = 32'hDEADBEEF;
            end
            tick;
        end
        DMEM_ACK = 1'b0;
        DMEM_RDATA = 32'h0;
        chk("lw_wb_we", {31'd0, WE}, 32'd1);
        chk("lw_wb_wadr", {27'd0, WADR}, 32'd8);
        chk("lw_wb_wdata", Wdata, 32'hDEADBEEF);
        chk("lw_wb_stall", {31'd0, STALL}, 32'd1);
        chk("lw_wb_req", {31'd0, DMEM_REQ}, 32'd0);
        tick;
        chk("lw_post_we", {31'd0, WE}, 32'd0);
        chk("lw_post_stall", {31'd0, STALL}, 32'd0);
        // SW @0x44 data 5
        issue(it(6'h2b, 5'd9, 16'h44), 32'h44, 32'h5);
        chk("sw_req", {31'd0, DMEM_REQ}, 32'd1);
        chk("sw_dwe", {31'd0, DMEM_WE}, 32'd1);
        chk("sw_addr", DMEM_ADDR, 32'h44);
        chk("sw_wdata", DMEM_WDATA, 32'h5);
        DMEM_ACK = 1'b1;
        tick;
        DMEM_ACK = 1'b0;
        chk("sw_done_req", {31'd0, DMEM_REQ}, 32'd0);
        chk("sw_done_stall", {31'd0, STALL}, 32'd0);
        chk("sw_done_we", {31'd0, WE}, 32'd0);
        tick;
        chk("sw_no_we", {31'd0, WE}, 32'd0);
        // LW with no ACK: timeout after 16 request cycles
        issue(it(6'h23, 5'd4, 16'h80), 32'h80, 32'h0);
        reqc = 0;
        saw_we = 1'b0;
        for (int k = 0; k < 40 && DMEM_REQ; k++) begin
            reqc++;
            saw_we |= WE;
            tick;
        end
        chk("to_req_cycles", reqc, 32'd16);
        chk("to_err", {31'd0, ERR}, 32'd1);
        chk("to_no_we_wait", {31'd0, saw_we}, 32'd0);
        chk("to_we", {31'd0, WE}, 32'd0);
        chk("to_stall", {31'd0, STALL}, 32'd0);
        tick;
        chk("to_err_sticky", {31'd0, ERR}, 32'd1);
        chk("to_we_after", {31'd0, WE}, 32'd0);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("rst_clears_err", {31'd0, ERR}, 32'd0);
        // ACK on the very last allowed cycle is a success
        issue(it(6'h23, 5'd6, 16'h90), 32'h90, 32'h0);
        for (int k = 0; k < 15; k++) tick;
        chk("edge_req_last", {31'd0, DMEM_REQ}, 32'd1);
        DMEM_ACK = 1'b1;
        DMEM_RDATA = 32'hA5A5A5A5;
        tick;
        DMEM_ACK = 1'b0;
        chk("edge_we", {31'd0, WE}, 32'd1);
        chk("edge_wdata", Wdata, 32'hA5A5A5A5);
        chk("edge_wadr", {27'd0, WADR}, 32'd6);
        chk("edge_err", {31'd0, ERR}, 32'd0);
        tick;
        // RST in MEM, late ACK ignored
        issue(it(6'h23, 5'd2, 16'hC0), 32'hC0, 32'h0);
        chk("rstmem_req", {31'd0, DMEM_REQ}, 32'd1);
        RST = 1'b1;
        tick;
        RST = 1'b0;
        chk("rstmem_req_drop", {31'd0, DMEM_REQ}, 32'd0);
        chk("rstmem_stall", {31'd0, STALL}, 32'd0);
        DMEM_ACK = 1'b1;
        DMEM_RDATA = 32'h12345678;
        tick;
        DMEM_ACK = 1'b0;
        chk("late_ack_we", {31'd0, WE}, 32'd0);
        chk("late_ack_stall", {31'd0, STALL}, 32'd0);
        tick;
        chk("late_ack_we2", {31'd0, WE}, 32'd0);
        // LW rt=0: access occurs, no register write
        issue(it(6'h23, 5'd0, 16'hD0), 32'hD0, 32'h0);
        chk("lw0_req", {31'd0, DMEM_REQ}, 32'd1);
        DMEM_ACK = 1'b1;
        DMEM_RDATA = 32'hCAFEF00D;
        tick;
        DMEM_ACK = 1'b0;
        chk("lw0_we", {31'd0, WE}, 32'd0);
        chk("lw0_wb_stall", {31'd0, STALL}, 32'd1);
        tick;
        chk("lw0_stall_clear", {31'd0, STALL}, 32'd0);
        chk("lw0_we_after", {31'd0, WE}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
